// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: word size, NOP encoding, reset PC and next-PC source selector.
package pipeline_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_RESET_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] CNT_MAX          = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    NPC_RESET,
    NPC_BRANCH,
    NPC_HOLD,
    NPC_JUMP,
    NPC_SEQ
  } npc_src_e;

  // Word-addressed PC: one instruction per step, wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(1);
  endfunction

  function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + XLEN'(1);
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch-stage event counters (fetched / killed / stalled), saturating at all-ones.
module fetch_perf_cnt
  import pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            br,
  input  logic            kill,
  output logic [XLEN-1:0] perf_fetched,
  output logic [XLEN-1:0] perf_killed,
  output logic [XLEN-1:0] perf_stalled
);

  logic [XLEN-1:0] fetched_q, fetched_d;
  logic [XLEN-1:0] killed_q, killed_d;
  logic [XLEN-1:0] stalled_q, stalled_d;

  // Exactly one counter advances per non-reset cycle; a branch during stall counts as a kill.
  always_comb begin
    fetched_d = fetched_q;
    killed_d  = killed_q;
    stalled_d = stalled_q;
    if (reset) begin
      fetched_d = '0;
      killed_d  = '0;
      stalled_d = '0;
    end else if (stall && !br) begin
      stalled_d = sat_inc(stalled_q);
    end else if (kill) begin
      killed_d = sat_inc(killed_q);
    end else begin
      fetched_d = sat_inc(fetched_q);
    end
  end

  always_ff @(posedge clk) begin
    fetched_q <= fetched_d;
    killed_q  <= killed_d;
    stalled_q <= stalled_d;
  end

  assign perf_fetched = fetched_q;
  assign perf_killed  = killed_q;
  assign perf_stalled = stalled_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, redirect priority, kill/flush generation.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int unsigned IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               jump_ID,
  input  logic [XLEN-1:0]    jump_target_ID,
  input  logic               branch_EX,
  input  logic [XLEN-1:0]    branch_target_EX,
  input  logic [XLEN-1:0]    imem_data,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [XLEN-1:0]    PC_F,
  output logic [XLEN-1:0]    Instruction_F,
  output logic [XLEN-1:0]    NPC_F,
  output logic               kill_F,
  output logic               flush_ID
`ifdef FETCH_PERF_EN
  ,
  output logic [XLEN-1:0]    perf_fetched,
  output logic [XLEN-1:0]    perf_killed,
  output logic [XLEN-1:0]    perf_stalled
`endif
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            br, jp;
  npc_src_e        npc_src;

  // A stalled jump is dropped rather than queued; ID re-presents it once the stall lifts.
  assign br = branch_EX & ~reset;
  assign jp = jump_ID & ~stall & ~reset & ~br;

  always_comb begin
    if (reset) begin
      npc_src = NPC_RESET;
    end else if (br) begin
      npc_src = NPC_BRANCH;
    end else if (stall) begin
      npc_src = NPC_HOLD;
    end else if (jp) begin
      npc_src = NPC_JUMP;
    end else begin
      npc_src = NPC_SEQ;
    end
  end

  always_comb begin
    pc_d = pc_q;
    unique case (npc_src)
      NPC_RESET:  pc_d = PC_RESET;
      NPC_BRANCH: pc_d = branch_target_EX;
      NPC_HOLD:   pc_d = pc_q;
      NPC_JUMP:   pc_d = jump_target_ID;
      NPC_SEQ:    pc_d = pc_inc(pc_q);
      default:    pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    pc_q <= pc_d;
  end

  assign PC_F          = pc_q;
  assign imem_addr     = pc_q[IMEM_AW-1:0];
  assign Instruction_F = imem_data;
  assign NPC_F         = reset ? pc_inc(PC_RESET) : pc_inc(pc_q);
  assign kill_F        = reset | br | jp;
  // The jump itself sits in ID, so only a branch marks ID as wrong-path.
  assign flush_ID      = reset | br;

`ifdef FETCH_PERF_EN
  fetch_perf_cnt u_perf (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .br           (br),
    .kill         (kill_F),
    .perf_fetched (perf_fetched),
    .perf_killed  (perf_killed),
    .perf_stalled (perf_stalled)
  );
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage. Owns the program counter, drives the instruction-memory address, and produces Instruction_F, NPC_F and kill toward the IF/ID buffer. It resolves redirects from ID (jump/call/return) and EX (taken branch) with fixed priority, honours hazard stalls, and generates flush for wrong-path instructions. The PC is word-addressed and increments by 1 per instruction.

Parameters:
PC_RESET, 32'h00000000, PC value loaded on reset
IMEM_AW, 10, instruction-memory word-address width (imem_addr = PC[IMEM_AW-1:0])

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
stall  in  1  hazard-unit stall; holds PC; same signal drives IF_ID disable_IR
jump_ID  in  1  ID-stage unconditional redirect (jump/call/return)
jump_target_ID  in  32  target for jump_ID
branch_EX  in  1  EX-stage taken-branch redirect
branch_target_EX  in  32  target for branch_EX
imem_data  in  32  combinational instruction-memory read data for imem_addr
imem_addr  out  IMEM_AW  instruction-memory word address
PC_F  out  32  current fetch PC
Instruction_F  out  32  = imem_data, passed through
NPC_F  out  32  PC_F + 1, modulo 2^32
kill_F  out  1  IF_ID kill: current fetch is wrong-path, latch NOP
flush_ID  out  1  ID-stage instruction is wrong-path; hazard unit bubbles ID_EX

Behaviour:
- State: PC register (32 b); all other outputs are combinational from PC and inputs.
- Reset: PC <= PC_RESET on a reset edge. While reset is high: kill_F=1, flush_ID=1, and both redirects are ignored. NPC_F=PC_RESET+1.
- Gated redirects: br = branch_EX & ~reset; jp = jump_ID & ~stall & ~reset & ~br.
- Next-PC priority, evaluated each edge (highest first):
  1 reset -> PC_RESET
  2 br -> branch_target_EX; branch overrides stall because the stalled ID instruction is wrong-path.
  3 stall -> PC held
  4 jp -> jump_target_ID
  5 otherwise -> PC+1 (wraps 32'hFFFFFFFF -> 0)
- kill_F = reset | br | jp. The instruction fetched in the redirect cycle is discarded. IF_ID writes a NOP because disable_IR is low in the jp case. In the br-with-stall case, the hazard unit must deassert disable_IR when flush_ID is high.
- flush_ID = reset | br. A jump does not flush ID because the jump itself occupies ID.
- Redirect penalty: jump = 1 bubble, branch = 2 bubbles. Fetch from the target appears on imem_addr in the cycle after the redirect.
- jump_ID while stall=1 is dropped. The jump re-asserts when the stall releases.
- Simultaneous branch_EX and jump_ID: the branch wins and the jump is discarded as wrong-path.
- Consecutive redirects on back-to-back cycles are legal. Each one independently reloads PC and asserts kill_F.
- Targets are used as given, with no alignment checks. imem_addr truncates to IMEM_AW bits.

Optional Feature:
FETCH_PERF_EN: adds 32-bit saturating counters perf_fetched, perf_killed and perf_stalled as extra output ports.
- All three counters clear on reset.
- Per cycle, outside reset:
  - perf_stalled increments when stall & ~br.
  - else perf_killed increments when kill_F.
  - else perf_fetched increments.
- Counters hold at 32'hFFFFFFFF.
- Without the macro, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package (pipeline_pkg) holds:
  - NOP_INSTR = 32'h00000000
  - XLEN = 32
  - PC_RESET default
  - the next-PC source enum: NPC_RESET, NPC_BRANCH, NPC_HOLD, NPC_JUMP, NPC_SEQ
- One sub-module, fetch_perf_cnt, is instantiated only under FETCH_PERF_EN. It takes stall, br and kill_F and returns the three counters.
- The next-PC mux stays inline.

Test Plan:
- Reset held 3 cycles, then released with no redirects -> PC_F sequence 0,1,2,3. NPC_F = PC_F+1. kill_F=1 only during reset.
- At PC=5, jump_ID=1 with target 32'h40 -> that cycle kill_F=1, flush_ID=0. Next cycle PC_F=32'h40, then 32'h41.
- At PC=8, stall=1 for 2 cycles with jump_ID=1 -> PC held at 8, kill_F=0. After the stall releases, the jump is taken the following cycle.
- At PC=12, branch_EX=1 with target 32'h100, simultaneous with stall=1 and jump_ID (target 32'h200) -> kill_F=1, flush_ID=1. Next PC_F=32'h100.
- PC_RESET=32'hFFFFFFFF, run 2 cycles -> PC_F FFFFFFFF then 00000000. NPC_F at FFFFFFFF is 0.
- FETCH_PERF_EN: 10 cycles containing 1 jump, 1 branch and 2 stall cycles -> perf_fetched=6, perf_killed=2, perf_stalled=2.
